// File: rtl/axis_i2c_arbiter.sv
// Round-robin, packet-locked arbiter sharing one AXI-Stream command port between
// NUM_REQ requesters, with a watchdog that revokes a grant stalled mid-packet.
module axis_i2c_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic [NUM_REQ-1:0]              s_tvalid,
  output logic [NUM_REQ-1:0]              s_tready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_REQ-1:0]              s_tlast,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tlast,
  output logic [$clog2(NUM_REQ)-1:0]      m_tid,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            timeout_err
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] g_idx, g_n;
  logic [IDW-1:0] rr_ptr, rr_n;
  logic [WDW-1:0] wd_cnt, wd_n;
  logic           rev_pend, pend_n;
  logic           err_n;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  int unsigned    cand;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [IDW-1:0]        next_ptr;
  logic                  revoke;

  assign sel_valid = s_tvalid[g_idx];
  assign sel_last  = s_tlast[g_idx];
  assign sel_data  = s_tdata[g_idx*DATA_WIDTH +: DATA_WIDTH];
  assign next_ptr  = (g_idx == LAST_IDX) ? '0 : g_idx + 1'b1;

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_REQ;
      if (!pick_found && s_tvalid[IDW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(cand);
      end
    end
  end

  // Once the revoke beat is presented it stays up until accepted, so m_tvalid
  // never drops without a handshake even if the requester wakes up again.
  always_comb begin
    state_n  = state;
    g_n      = g_idx;
    rr_n     = rr_ptr;
    wd_n     = wd_cnt;
    pend_n   = rev_pend;
    err_n    = 1'b0;
    revoke   = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    m_tid    = '0;
    s_tready = '0;
    grant    = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = LOCK;
          g_n     = pick_idx;
          wd_n    = '0;
          pend_n  = 1'b0;
        end
      end
      LOCK: begin
        grant[g_idx] = 1'b1;
        m_tid        = g_idx;
        revoke       = rev_pend || ((wd_cnt == WD_MAX) && !sel_valid);
        if (revoke) begin
          m_tvalid = 1'b1;
          m_tlast  = 1'b1;
          if (m_tready) begin
            state_n = IDLE;
            rr_n    = next_ptr;
            err_n   = 1'b1;
            pend_n  = 1'b0;
          end else begin
            pend_n  = 1'b1;
          end
        end else begin
          m_tvalid        = sel_valid;
          m_tdata         = sel_data;
          m_tlast         = sel_last;
          s_tready[g_idx] = m_tready;
          if (sel_valid && m_tready && sel_last) begin
            state_n = IDLE;
            rr_n    = next_ptr;
          end else if (sel_valid) begin
            wd_n = '0;
          end else begin
            wd_n = wd_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      g_idx       <= '0;
      rr_ptr      <= '0;
      wd_cnt      <= '0;
      rev_pend    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      g_idx       <= g_n;
      rr_ptr      <= rr_n;
      wd_cnt      <= wd_n;
      rev_pend    <= pend_n;
      timeout_err <= err_n;
    end
  end

endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// Bench for axis_i2c_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a packet-level model.
module tb_axis_i2c_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [N-1:0]  s_tvalid = '0;
  logic [N-1:0]  s_tready;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N-1:0]  s_tlast = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [1:0]    m_tid;
  logic [N-1:0]  grant;
  logic          timeout_err;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;

  axis_i2c_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .arst_n(arst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tid(m_tid), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packet-level reference: who owns the port, where the pointer is, how long
  // the owner has been silent, and whether a revoke beat is outstanding.
  int md_lock, md_g, md_rr, md_cnt, md_pend;
  bit md_err;

  always @(posedge clk or negedge arst_n) begin
    int pick;
    bit found;
    bit rv;
    if (!arst_n) begin
      md_lock <= 0; md_g <= 0; md_rr <= 0; md_cnt <= 0; md_pend <= 0; md_err <= 0;
    end else begin
      md_err <= 0;
      if (md_lock == 0) begin
        found = 0;
        pick = 0;
        for (int k = 0; k < N; k++)
          if (!found && s_tvalid[(md_rr + k) % N]) begin
            found = 1;
            pick = (md_rr + k) % N;
          end
        if (found) begin
          md_lock <= 1; md_g <= pick; md_cnt <= 0; md_pend <= 0;
        end
      end else begin
        rv = (md_pend != 0) || (md_cnt == T - 1 && !s_tvalid[md_g]);
        if (rv) begin
          if (m_tready) begin
            md_lock <= 0; md_rr <= (md_g + 1) % N; md_err <= 1; md_pend <= 0;
          end else md_pend <= 1;
        end else if (s_tvalid[md_g] && m_tready && s_tlast[md_g]) begin
          md_lock <= 0; md_rr <= (md_g + 1) % N;
        end else if (s_tvalid[md_g]) md_cnt <= 0;
        else md_cnt <= md_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg, er;
    logic ev, el;
    logic [DW-1:0] ed;
    logic [1:0] et;
    eg = '0; er = '0; ev = 0; el = 0; ed = '0; et = '0;
    if (md_lock != 0) begin
      eg[md_g] = 1'b1;
      et = 2'(md_g);
      if ((md_pend != 0) || (md_cnt == T - 1 && !s_tvalid[md_g])) begin
        ev = 1; el = 1;
      end else begin
        ev = s_tvalid[md_g];
        ed = s_tdata[md_g*DW +: DW];
        el = s_tlast[md_g];
        er[md_g] = m_tready;
      end
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("m_tid", 32'(m_tid), 32'(et));
    chk("m_tvalid", 32'(m_tvalid), 32'(ev));
    chk("m_tdata", 32'(m_tdata), 32'(ed));
    chk("m_tlast", 32'(m_tlast), 32'(el));
    chk("s_tready", 32'(s_tready), 32'(er));
    chk("timeout_err", 32'(timeout_err), 32'(md_err));
    if (timeout_err) err_seen++;
  end

  int beat[N], len[N], dead[N], seq[N];
  logic [N-1:0] acc, gs;
  int es;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'h0);
    step(); arst_n = 1'b1;

    // 1: single requester, three beats, one bubble before the first beat
    step();
    s_tvalid = 4'b0001; s_tdata[15:0] = 16'hA001; s_tlast = '0; m_tready = 1'b1;
    @(negedge clk); chk("t1_bubble_grant", 32'(grant), 32'h0);
    chk("t1_bubble_valid", 32'(m_tvalid), 32'h0);
    step(); @(negedge clk);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_beat1", 32'(m_tdata), 32'hA001);
    step(); s_tdata[15:0] = 16'hA002;
    @(negedge clk); chk("t1_beat2", 32'(m_tdata), 32'hA002);
    step(); s_tdata[15:0] = 16'hA003; s_tlast = 4'b0001;
    @(negedge clk); chk("t1_beat3", 32'(m_tdata), 32'hA003);
    chk("t1_last", 32'(m_tlast), 32'h1);
    step(); s_tvalid = '0; s_tlast = '0;
    @(negedge clk); chk("t1_idle", 32'(grant), 32'h0);

    // 2: Req0 and Req2 together with pointer at 0
    step(); arst_n = 1'b0;
    step(); arst_n = 1'b1;
    s_tvalid = 4'b0101; s_tlast = 4'b0101;
    s_tdata[15:0] = 16'h2000; s_tdata[47:32] = 16'h2222;
    @(negedge clk); chk("t2_bubble", 32'(grant), 32'h0);
    step(); @(negedge clk);
    chk("t2_first", 32'(grant), 32'h1); chk("t2_data0", 32'(m_tdata), 32'h2000);
    step(); s_tvalid[0] = 1'b0;
    @(negedge clk); chk("t2_gap", 32'(grant), 32'h0);
    step(); @(negedge clk);
    chk("t2_second", 32'(grant), 32'h4); chk("t2_tid", 32'(m_tid), 32'h2);
    chk("t2_data2", 32'(m_tdata), 32'h2222);
    step(); s_tvalid = '0;
    @(negedge clk); chk("t2_idle", 32'(grant), 32'h0);

    // 3: pointer at 3 with Req3 and Req1 pending -> 3, then wrap to 1
    step();
    s_tvalid = 4'b1010; s_tlast = 4'b1010;
    s_tdata[63:48] = 16'h3333; s_tdata[31:16] = 16'h1111;
    step(); @(negedge clk); chk("t3_first", 32'(grant), 32'h8);
    step(); s_tvalid[3] = 1'b0;
    @(negedge clk); chk("t3_gap", 32'(grant), 32'h0);
    step(); @(negedge clk);
    chk("t3_second", 32'(grant), 32'h2); chk("t3_data1", 32'(m_tdata), 32'h1111);
    step(); s_tvalid = '0; s_tlast = '0;

    // 4: long downstream stall with the owner still valid never trips the watchdog
    step();
    s_tvalid = 4'b0010; s_tdata[31:16] = 16'h4444; m_tready = 1'b0;
    step(); @(negedge clk); chk("t4_grant", 32'(grant), 32'h2);
    es = err_seen;
    repeat (2000) step();
    @(negedge clk);
    chk("t4_held_data", 32'(m_tdata), 32'h4444);
    chk("t4_held_grant", 32'(grant), 32'h2);
    chk("t4_no_timeout", 32'(err_seen - es), 32'h0);
    step(); m_tready = 1'b1; s_tlast = 4'b0010;
    step(); s_tvalid = '0; s_tlast = '0;
    @(negedge clk); chk("t4_done", 32'(grant), 32'h0);

    // 5: owner goes silent after one beat -> revoke beat on 16th silent cycle
    step();
    s_tvalid = 4'b0100; s_tdata[47:32] = 16'h5555;
    step(); @(negedge clk); chk("t5_grant", 32'(grant), 32'h4);
    step(); s_tvalid = 4'b1000; s_tlast = 4'b1000; s_tdata[63:48] = 16'h5333;
    for (int c = 0; c < T - 1; c++) begin
      @(negedge clk); chk("t5_quiet", 32'(m_tvalid), 32'h0);
      step();
    end
    @(negedge clk);
    chk("t5_rev_valid", 32'(m_tvalid), 32'h1);
    chk("t5_rev_data", 32'(m_tdata), 32'h0);
    chk("t5_rev_last", 32'(m_tlast), 32'h1);
    chk("t5_rev_ready", 32'(s_tready), 32'h0);
    step(); @(negedge clk);
    chk("t5_pulse", 32'(timeout_err), 32'h1);
    chk("t5_idle", 32'(grant), 32'h0);
    step(); @(negedge clk);
    chk("t5_next", 32'(grant), 32'h8);
    step(); s_tvalid = '0; s_tlast = '0;
    @(negedge clk); chk("t5_pulse_once", 32'(timeout_err), 32'h0);

    // 6: reset during beat 2 clears everything and the pointer
    step();
    s_tvalid = 4'b0010; s_tdata[31:16] = 16'h6661;
    step(); @(negedge clk); chk("t6_grant", 32'(grant), 32'h2);
    step(); s_tdata[31:16] = 16'h6662;
    #2 arst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_valid", 32'(m_tvalid), 32'h0);
    chk("t6_rst_data", 32'(m_tdata), 32'h0);
    chk("t6_rst_ready", 32'(s_tready), 32'h0);
    step(); arst_n = 1'b1;
    s_tvalid = 4'b0011; s_tlast = 4'b0011; s_tdata[15:0] = 16'h7000;
    step(); @(negedge clk);
    chk("t6_restart", 32'(grant), 32'h1);
    step(); s_tvalid = '0; s_tlast = '0;

    // randomized traffic with occasional abandoned packets
    for (int i = 0; i < N; i++) begin
      beat[i] = 0; len[i] = 1 + int'($urandom % 4); dead[i] = 0; seq[i] = 0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      acc = s_tvalid & s_tready;
      gs = grant;
      step();
      m_tready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          if (beat[i] == len[i] - 1) begin
            beat[i] = 0; len[i] = 1 + int'($urandom % 4); seq[i]++;
          end else beat[i]++;
        end
        if (dead[i] > 0) begin
          dead[i]--; s_tvalid[i] = 1'b0;
        end else if (gs[i] && ($urandom % 64) == 0) begin
          dead[i] = 20 + int'($urandom % 6); beat[i] = 0; s_tvalid[i] = 1'b0;
        end else s_tvalid[i] = ($urandom % 4) != 0;
        s_tdata[i*DW +: DW] = {4'(i), 4'(seq[i]), 8'(beat[i])};
        s_tlast[i] = (beat[i] == len[i] - 1);
      end
    end
    step(); s_tvalid = '0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
